// File: rtl/multicycle_ctrl_unit.sv
// Control unit for a multicycle MIPS-style datapath with HI/LO multiply support.
// Moore FSM clocked on the falling edge; outputs registered alongside the state.
module multicycle_ctrl_unit #(
  parameter bit          MEM_WAIT_EN = 1'b1,
  parameter bit          MULT_EN     = 1'b1,
  parameter int unsigned MULT_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       regDest,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic       hiWrite,
  output logic       loWrite,
  output logic [1:0] memToReg,
  output logic [1:0] pcSrc,
  output logic       pcWrite,
  output logic       branch,
  output logic       illegal
);

  localparam int unsigned STATE_W = 4;
  localparam int unsigned CNT_W   = 4;
  localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);

  localparam logic [5:0] OP_MULT = 6'b011000;
  localparam logic [5:0] OP_MFHL = 6'b010000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MULT     = 4'd2,
    S_HILO     = 4'd3,
    S_MFHL     = 4'd4,
    S_BEQ      = 4'd5,
    S_ADDI_EX  = 4'd6,
    S_ADDI_WB  = 4'd7,
    S_MEM_ADDR = 4'd8,
    S_LW_RD    = 4'd9,
    S_LW_WB    = 4'd10,
    S_SW_WR    = 4'd11,
    S_JUMP     = 4'd12,
    S_ILLEGAL  = 4'd13
  } state_t;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       reg_dest;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       hi_write;
    logic       lo_write;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_src;
    logic       pc_write;
    logic       branch;
    logic       illegal;
    logic       fetch;
  } ctrl_t;

  state_t           r_state;
  state_t           w_next_state;
  ctrl_t            r_ctrl;
  ctrl_t            w_ctrl;
  logic [CNT_W-1:0] r_mult_cnt;
  logic             w_mem_ok;
  logic             w_fetch_done;

  // Moore output decode for a given state; funct only selects HI vs LO on writeback.
  function automatic ctrl_t decode_ctrl(input state_t s, input logic [5:0] f);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        c.pc_src    = 2'b10;
        c.fetch     = 1'b1;
      end
      S_DECODE: c.alu_src_b = 2'b11;
      S_MULT: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
      end
      S_HILO: begin
        c.hi_write = 1'b1;
        c.lo_write = 1'b1;
      end
      S_MFHL: begin
        c.reg_dest   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = (f == F_MFLO) ? 2'b11 : 2'b01;
      end
      S_BEQ: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_ADDI_EX, S_MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
      end
      S_ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 2'b10;
      end
      S_LW_RD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
      end
      S_LW_WB: c.reg_write = 1'b1;
      S_SW_WR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      S_JUMP: begin
        c.pc_src   = 2'b01;
        c.pc_write = 1'b1;
      end
      S_ILLEGAL: c.illegal = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  assign w_mem_ok = mem_ready | ~MEM_WAIT_EN;

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_FETCH:  if (w_mem_ok) w_next_state = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_MULT: w_next_state = MULT_EN ? S_MULT : S_ILLEGAL;
          OP_MFHL: w_next_state = ((funct == F_MFHI) || (funct == F_MFLO)) ? S_MFHL : S_ILLEGAL;
          OP_BEQ:  w_next_state = S_BEQ;
          OP_ADDI: w_next_state = S_ADDI_EX;
          OP_LW,
          OP_SW:   w_next_state = S_MEM_ADDR;
          OP_J:    w_next_state = S_JUMP;
          default: w_next_state = S_ILLEGAL;
        endcase
      end
      S_MULT:     if (r_mult_cnt == MULT_LAST) w_next_state = S_HILO;
      S_HILO:     w_next_state = S_FETCH;
      S_MFHL:     w_next_state = S_FETCH;
      S_BEQ:      w_next_state = S_FETCH;
      S_ADDI_EX:  w_next_state = S_ADDI_WB;
      S_ADDI_WB:  w_next_state = S_FETCH;
      S_MEM_ADDR: begin
        if (opcode == OP_LW)      w_next_state = S_LW_RD;
        else if (opcode == OP_SW) w_next_state = S_SW_WR;
        else                      w_next_state = S_ILLEGAL;
      end
      S_LW_RD:    if (w_mem_ok) w_next_state = S_LW_WB;
      S_LW_WB:    w_next_state = S_FETCH;
      S_SW_WR:    if (w_mem_ok) w_next_state = S_FETCH;
      S_JUMP:     w_next_state = S_FETCH;
      S_ILLEGAL:  w_next_state = S_ILLEGAL;
      default:    w_next_state = S_FETCH;
    endcase
  end

  // State, multiply counter and registered outputs; reset loads FETCH decode.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_FETCH;
      r_mult_cnt <= '0;
      r_ctrl     <= decode_ctrl(S_FETCH, 6'd0);
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= decode_ctrl(w_next_state, funct);
      if ((r_state == S_MULT) && (r_mult_cnt != MULT_LAST)) begin
        r_mult_cnt <= r_mult_cnt + CNT_W'(1);
      end else begin
        r_mult_cnt <= '0;
      end
    end
  end

  // Everything is held low while reset is asserted.
  assign w_ctrl       = reset ? '0 : r_ctrl;
  assign w_fetch_done = w_ctrl.fetch & w_mem_ok;

  assign IorD     = w_ctrl.iord;
  assign memRead  = w_ctrl.mem_read;
  assign memWrite = w_ctrl.mem_write;
  assign IRWrite  = w_fetch_done;
  assign regDest  = w_ctrl.reg_dest;
  assign regWrite = w_ctrl.reg_write;
  assign aluSrcA  = w_ctrl.alu_src_a;
  assign aluSrcB  = w_ctrl.alu_src_b;
  assign aluOp    = w_ctrl.alu_op;
  assign hiWrite  = w_ctrl.hi_write;
  assign loWrite  = w_ctrl.lo_write;
  assign memToReg = w_ctrl.mem_to_reg;
  assign pcSrc    = w_ctrl.pc_src;
  assign pcWrite  = w_ctrl.pc_write | w_fetch_done;
  assign branch   = w_ctrl.branch;
  assign illegal  = w_ctrl.illegal;

endmodule

// File: tb/tb_multicycle_ctrl_unit.sv
// Directed bench for multicycle_ctrl_unit: one instance with a 4-cycle multiplier,
// a second with multiply disabled, both driven by the same instruction stream.
module tb_multicycle_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       mem_ready = 1'b0;

  logic       IorD, memRead, memWrite, IRWrite, regDest, regWrite, aluSrcA;
  logic [1:0] aluSrcB, aluOp, memToReg, pcSrc;
  logic       hiWrite, loWrite, pcWrite, branch, illegal;

  logic       IorD_n, memRead_n, memWrite_n, IRWrite_n, regDest_n, regWrite_n, aluSrcA_n;
  logic [1:0] aluSrcB_n, aluOp_n, memToReg_n, pcSrc_n;
  logic       hiWrite_n, loWrite_n, pcWrite_n, branch_n, illegal_n;

  logic [19:0] w_all;
  assign w_all = {IorD, memRead, memWrite, IRWrite, regDest, regWrite, aluSrcA, aluSrcB,
                  aluOp, hiWrite, loWrite, memToReg, pcSrc, pcWrite, branch, illegal};

  multicycle_ctrl_unit #(.MEM_WAIT_EN(1'b1), .MULT_EN(1'b1), .MULT_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .IorD(IorD), .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite),
    .regDest(regDest), .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
    .aluOp(aluOp), .hiWrite(hiWrite), .loWrite(loWrite), .memToReg(memToReg),
    .pcSrc(pcSrc), .pcWrite(pcWrite), .branch(branch), .illegal(illegal)
  );

  multicycle_ctrl_unit #(.MEM_WAIT_EN(1'b1), .MULT_EN(1'b0), .MULT_CYCLES(4)) dut_nm (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .mem_ready(mem_ready),
    .IorD(IorD_n), .memRead(memRead_n), .memWrite(memWrite_n), .IRWrite(IRWrite_n),
    .regDest(regDest_n), .regWrite(regWrite_n), .aluSrcA(aluSrcA_n), .aluSrcB(aluSrcB_n),
    .aluOp(aluOp_n), .hiWrite(hiWrite_n), .loWrite(loWrite_n), .memToReg(memToReg_n),
    .pcSrc(pcSrc_n), .pcWrite(pcWrite_n), .branch(branch_n), .illegal(illegal_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int pcw_cnt;
  int rw_cnt;
  int rd_cnt;

  int lw_st [11] = '{0, 0, 0, 0, 1, 8, 9, 9, 9, 10, 0};
  bit lw_mr [11] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // One falling-edge cycle: drive mem_ready for the coming edge, then check the current state.
  task automatic step(input logic mr, input int exp_st, input string tag);
    @(posedge clk);
    mem_ready = mr;
    #1;
    check_eq(tag, 32'(dut.r_state), 32'(exp_st));
    pcw_cnt += int'(pcWrite);
    rw_cnt  += int'(regWrite);
    rd_cnt  += int'(regDest);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    reset = 1'b1;
    #1;
    check_eq({tag, "_outs_in_reset"}, 32'(w_all), 32'd0);
    check_eq({tag, "_state_in_reset"}, 32'(dut.r_state), 32'd0);
    @(posedge clk);
    mem_ready = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    check_eq({tag, "_state_after"}, 32'(dut.r_state), 32'd0);
    check_eq({tag, "_memRead_after"}, 32'(memRead), 32'd1);
  endtask

  initial begin
    #1 reset = 1'b1;
    @(posedge clk);
    #1;
    check_eq("reset_outs", 32'(w_all), 32'd0);
    check_eq("reset_state", 32'(dut.r_state), 32'd0);
    check_eq("reset_illegal_nm", 32'(illegal_n), 32'd0);
    opcode = 6'b100011;
    reset = 1'b0;
    #1;
    check_eq("fetch_aluSrcB", 32'(aluSrcB), 32'd1);
    check_eq("fetch_pcSrc", 32'(pcSrc), 32'd2);
    check_eq("fetch_wait_IRWrite", 32'(IRWrite), 32'd0);

    // lw with fetch and read wait states
    pcw_cnt = 0; rw_cnt = 0; rd_cnt = 0;
    for (int i = 0; i < 11; i++) begin
      step(lw_mr[i], lw_st[i], $sformatf("lw_state_c%0d", i));
      if (i == 3) check_eq("lw_IRWrite_ready", 32'(IRWrite), 32'd1);
      if (i == 6) check_eq("lw_rd_IorD", 32'(IorD), 32'd1);
      if (i == 9) check_eq("lw_wb_memToReg", 32'(memToReg), 32'd0);
    end
    check_eq("lw_pcWrite_pulses", 32'(pcw_cnt), 32'd1);
    check_eq("lw_regWrite_pulses", 32'(rw_cnt), 32'd1);

    // sw, memory always ready
    opcode = 6'b101011;
    rw_cnt = 0;
    begin
      int sw_st [5] = '{0, 1, 8, 11, 0};
      for (int i = 0; i < 5; i++) begin
        step(i < 4 ? 1'b1 : 1'b0, sw_st[i], $sformatf("sw_state_c%0d", i));
        check_eq($sformatf("sw_memWrite_c%0d", i), 32'(memWrite), 32'(sw_st[i] == 11));
      end
    end
    check_eq("sw_regWrite_never", 32'(rw_cnt), 32'd0);

    // mflo then mfhi
    opcode = 6'b010000;
    funct  = 6'b010010;
    rd_cnt = 0;
    step(1'b1, 0, "mflo_c0");
    step(1'b1, 1, "mflo_c1");
    step(1'b1, 4, "mflo_c2");
    check_eq("mflo_memToReg", 32'(memToReg), 32'd3);
    check_eq("mflo_regDest", 32'(regDest), 32'd1);
    step(1'b0, 0, "mflo_c3");
    check_eq("mflo_regDest_once", 32'(rd_cnt), 32'd1);
    funct = 6'b010000;
    step(1'b1, 0, "mfhi_c0");
    step(1'b1, 1, "mfhi_c1");
    step(1'b1, 4, "mfhi_c2");
    check_eq("mfhi_memToReg", 32'(memToReg), 32'd1);

    // bad funct under the MFHL opcode traps
    funct = 6'b000001;
    step(1'b1, 0, "badfn_c0");
    step(1'b1, 1, "badfn_c1");
    step(1'b1, 13, "badfn_c2");
    check_eq("badfn_illegal", 32'(illegal), 32'd1);
    step(1'b1, 13, "badfn_c3");
    check_eq("badfn_no_memRead", 32'(memRead), 32'd0);
    do_reset("badfn_rst");
    check_eq("badfn_rst_illegal", 32'(illegal), 32'd0);

    // reset during the LW_RD wait aborts the load
    opcode = 6'b100011;
    funct  = 6'b000000;
    step(1'b1, 0, "lwab_c0");
    step(1'b0, 1, "lwab_c1");
    step(1'b0, 8, "lwab_c2");
    step(1'b0, 9, "lwab_c3");
    step(1'b0, 9, "lwab_c4");
    do_reset("lwab_rst");
    rw_cnt = 0;
    for (int i = 0; i < 3; i++) step(1'b0, 0, $sformatf("lwab_post_c%0d", i));
    check_eq("lwab_regWrite_never", 32'(rw_cnt), 32'd0);

    // 4-cycle multiply; the multiply-disabled instance traps instead
    opcode = 6'b011000;
    step(1'b1, 0, "mult_c0");
    step(1'b1, 1, "mult_c1");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 2, $sformatf("mult_busy_c%0d", i));
      check_eq($sformatf("mult_aluOp_c%0d", i), 32'(aluOp), 32'd2);
      check_eq($sformatf("mult_hi_idle_c%0d", i), 32'(hiWrite), 32'd0);
    end
    step(1'b0, 3, "mult_hilo");
    check_eq("mult_hilo_writes", 32'({hiWrite, loWrite}), 32'd3);
    step(1'b0, 0, "mult_done");
    check_eq("nm_state_trap", 32'(dut_nm.r_state), 32'd13);
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 0, $sformatf("nm_hold_c%0d", i));
      check_eq($sformatf("nm_illegal_c%0d", i), 32'(illegal_n), 32'd1);
    end
    do_reset("nm_rst");
    check_eq("nm_rst_illegal", 32'(illegal_n), 32'd0);
    check_eq("nm_rst_state", 32'(dut_nm.r_state), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
